// File: rtl/tpu_readout_pkg.sv
// Shared types and default sizes for the result SRAM readout path.
// Holds the readout FSM state encoding, the default geometry and ROW_W.
// No ports: this is a package imported by the readout modules.
package tpu_readout_pkg;

  localparam int DFLT_ADDRESSSIZE    = 10;
  localparam int DFLT_MATRIX_SIZE    = 8;
  localparam int DFLT_PARTIAL_SUM_BW = 20;

  // Width of one SRAM row: MATRIX_SIZE partial sums side by side.
  localparam int ROW_W = DFLT_PARTIAL_SUM_BW * DFLT_MATRIX_SIZE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  // Lane counter width; kept at least one bit for a single-lane row.
  function automatic int lane_cnt_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/row_serializer.sv
// Holds one SRAM row and presents it one lane at a time, lane 0 first.
// Latency: lane 0 is on o_lane the cycle after i_load; one lane per i_advance.
// Backpressure: o_lane and the lane counter hold while i_advance is low.
// Ports: clk/rstn, i_load + i_row (capture row, clear lane counter),
//        i_advance (step to next lane), o_lane (current lane), o_last_lane.
module row_serializer
  import tpu_readout_pkg::*;
#(
  parameter int MATRIX_SIZE    = DFLT_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DFLT_PARTIAL_SUM_BW
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 i_load,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] i_row,
  input  logic                                 i_advance,
  output logic [PARTIAL_SUM_BW-1:0]            o_lane,
  output logic                                 o_last_lane
);

  localparam int LANE_W = lane_cnt_w(MATRIX_SIZE);

  logic [PARTIAL_SUM_BW-1:0] r_lanes [MATRIX_SIZE];
  logic [LANE_W-1:0]         r_lane_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lane_cnt <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++) r_lanes[i] <= '0;
    end else if (i_load) begin
      r_lane_cnt <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++)
        r_lanes[i] <= i_row[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end else if (i_advance) begin
      r_lane_cnt <= r_lane_cnt + 1'b1;
    end
  end

  assign o_lane      = r_lanes[r_lane_cnt];
  assign o_last_lane = (r_lane_cnt == LANE_W'(MATRIX_SIZE - 1));

endmodule

// File: rtl/result_readout_ctrl.sv
// Drains num_rows result SRAM rows from base_addr into a lane-wide valid/ready stream.
// Latency: start at edge 0 -> read in cycle 1, first m_valid in cycle 3; 2+MATRIX_SIZE cycles/row.
// Backpressure: m_data/m_last hold while m_valid & !m_ready; no m_ready->m_valid comb path.
// Ports: clk/rstn, start/base_addr/num_rows (command), sram_rd_en/sram_address/
//        sram_rdata (SRAM read port), m_valid/m_ready/m_data/m_last (stream), busy/done.
module result_readout_ctrl
  import tpu_readout_pkg::*;
#(
  parameter int ADDRESSSIZE    = DFLT_ADDRESSSIZE,
  parameter int MATRIX_SIZE    = DFLT_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DFLT_PARTIAL_SUM_BW
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDRESSSIZE-1:0]               base_addr,
  input  logic [ADDRESSSIZE:0]                 num_rows,
  output logic                                 sram_rd_en,
  output logic [ADDRESSSIZE-1:0]               sram_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rdata,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [PARTIAL_SUM_BW-1:0]            m_data,
  output logic                                 m_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CW = ADDRESSSIZE + 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_row_cnt;
  logic [CW-1:0]         r_num_rows;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [CW-1:0]         w_row_next;
  logic                  w_handshake;
  logic                  w_last_lane;
  logic                  w_more_rows;
  logic [PARTIAL_SUM_BW-1:0] w_lane;

  assign w_handshake = (r_state == SEND) && m_ready;
  assign w_row_next  = r_row_cnt + CW'(1);
  assign w_more_rows = (w_row_next < r_num_rows);

  row_serializer #(
    .MATRIX_SIZE   (MATRIX_SIZE),
    .PARTIAL_SUM_BW(PARTIAL_SUM_BW)
  ) u_row_serializer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (r_state == WAIT),
    .i_row      (sram_rdata),
    .i_advance  (w_handshake),
    .o_lane     (w_lane),
    .o_last_lane(w_last_lane)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = (num_rows != '0) ? READ : DONE;
      READ: w_next_state = WAIT;
      WAIT: w_next_state = SEND;
      SEND: if (w_handshake && w_last_lane) w_next_state = w_more_rows ? READ : DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command capture, row counter and read address. The address register is
  // advanced alongside the row counter, so it always equals base+row_cnt
  // modulo the SRAM depth and simply holds between reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_row_cnt  <= '0;
      r_num_rows <= '0;
      r_addr     <= '0;
    end else if (r_state == IDLE && start) begin
      r_row_cnt  <= '0;
      r_num_rows <= num_rows;
      if (num_rows != '0) r_addr <= base_addr;
    end else if (w_handshake && w_last_lane && w_more_rows) begin
      r_row_cnt <= w_row_next;
      r_addr    <= r_addr + 1'b1;
    end
  end

  // Output decode
  always_comb begin
    sram_rd_en = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      READ: begin
        sram_rd_en = 1'b1;
        busy       = 1'b1;
      end
      WAIT: busy = 1'b1;
      SEND: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = w_last_lane && (w_row_next == r_num_rows);
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign sram_address = r_addr;
  assign m_data       = w_lane;

endmodule

// File: tb/tb_result_readout_ctrl.sv
// Self-checking bench for result_readout_ctrl with a behavioural result SRAM.
module tb_result_readout_ctrl;

  localparam int AW = 10;
  localparam int MS = 8;
  localparam int PW = 20;
  localparam int RW = PW * MS;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          sram_rd_en;
  logic [AW-1:0] sram_address;
  logic [RW-1:0] sram_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  result_readout_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .sram_rd_en  (sram_rd_en),
    .sram_address(sram_address),
    .sram_rdata  (sram_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  // Result SRAM: data_out valid one cycle after the address.
  logic [RW-1:0] mem [1024];
  always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_address];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] lane_of(input logic [AW-1:0] a, input int l);
    logic [RW-1:0] row;
    row = mem[a];
    return row[l*PW +: PW];
  endfunction

  task automatic set_lanes(input logic [AW-1:0] a, input logic [PW-1:0] v0, input logic [PW-1:0] v1,
                           input logic [PW-1:0] v2, input logic [PW-1:0] v3, input logic [PW-1:0] v4,
                           input logic [PW-1:0] v5, input logic [PW-1:0] v6, input logic [PW-1:0] v7);
    mem[a] = {v7, v6, v5, v4, v3, v2, v1, v0};
  endtask

  // One complete drain: issue start, step cycle by cycle (sampling on the
  // falling edge), collect reads and beats, then compare against the SRAM image.
  task automatic drain(input string nm, input logic [AW-1:0] base, input logic [AW:0] nrows,
                       input bit bp, input int poke_cyc);
    logic [AW-1:0] q_addr[$];
    logic [PW-1:0] q_beat[$];
    int first_rd = -1, first_vld = -1, last_cyc = -1, last_idx = -1;
    int n_last = 0, done_cyc = -1, n_vld = 0;
    logic busy1 = 1'b0;
    bit prev_stall = 1'b0;
    logic [PW-1:0] prev_dat = '0;
    logic prev_last = 1'b0;
    logic [AW-1:0] ea;
    int nr;
    nr = int'(nrows);
    @(negedge clk);
    start = 1'b1; base_addr = base; num_rows = nrows; m_ready = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin base_addr = 10'd99; num_rows = 11'd1; end
      m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == 1) busy1 = busy;
      if (prev_stall) begin
        chk_eq({nm, " stall_vld"}, 64'(m_valid), 64'd1);
        chk_eq({nm, " stall_dat"}, 64'(m_data), 64'(prev_dat));
        chk_eq({nm, " stall_last"}, 64'(m_last), 64'(prev_last));
      end
      if (sram_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        q_addr.push_back(sram_address);
      end
      if (m_valid) begin
        n_vld++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (m_valid && m_ready) begin
        q_beat.push_back(m_data);
        if (m_last) begin n_last++; last_idx = q_beat.size(); last_cyc = cyc; end
      end
      prev_stall = m_valid && !m_ready;
      prev_dat   = m_data;
      prev_last  = m_last;
      if (done) begin done_cyc = cyc; break; end
    end
    chk_eq({nm, " done_seen"}, 64'(done_cyc > 0), 64'd1);
    if (!bp) chk_eq({nm, " done_cyc"}, 64'(done_cyc), (nr == 0) ? 64'd1 : 64'(nr * (MS + 2) + 1));
    chk_eq({nm, " busy_c1"}, 64'(busy1), 64'(nr != 0));
    chk_eq({nm, " n_reads"}, 64'(q_addr.size()), 64'(nr));
    for (int i = 0; i < q_addr.size() && i < nr; i++) begin
      ea = base + AW'(i);
      chk_eq({nm, " rd_addr"}, 64'(q_addr[i]), 64'(ea));
    end
    chk_eq({nm, " n_beats"}, 64'(q_beat.size()), 64'(nr * MS));
    for (int i = 0; i < q_beat.size() && i < nr * MS; i++) begin
      ea = base + AW'(i / MS);
      chk_eq({nm, " beat"}, 64'(q_beat[i]), 64'(lane_of(ea, i % MS)));
    end
    if (nr > 0) begin
      chk_eq({nm, " first_rd_cyc"}, 64'(first_rd), 64'd1);
      chk_eq({nm, " first_vld_cyc"}, 64'(first_vld), 64'd3);
      chk_eq({nm, " n_last"}, 64'(n_last), 64'd1);
      chk_eq({nm, " last_idx"}, 64'(last_idx), 64'(nr * MS));
      if (!bp) chk_eq({nm, " last_cyc"}, 64'(last_cyc), 64'(nr * (MS + 2)));
    end else begin
      chk_eq({nm, " n_vld"}, 64'(n_vld), 64'd0);
    end
    @(negedge clk);
    chk_eq({nm, " done_width"}, 64'(done), 64'd0);
    chk_eq({nm, " busy_after"}, 64'(busy), 64'd0);
    chk_eq({nm, " vld_after"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    int saw_done;
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; m_ready = 1'b0;
    for (int a = 0; a < 1024; a++)
      for (int l = 0; l < MS; l++)
        mem[a][l*PW +: PW] = PW'(20'h30000 + a * 16 + l);
    set_lanes(10'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8);
    set_lanes(10'd20, 20'hFFFFF, 20'h00001, 20'hFFFFF, 20'h80000,
                      20'h7FFFF, 20'hFFFFF, 20'h00000, 20'hFFFFF);
    set_lanes(10'd21, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF,
                      20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);

    repeat (3) @(negedge clk);
    chk_eq("rst rd_en", 64'(sram_rd_en), 64'd0);
    chk_eq("rst addr", 64'(sram_address), 64'd0);
    chk_eq("rst valid", 64'(m_valid), 64'd0);
    chk_eq("rst data", 64'(m_data), 64'd0);
    chk_eq("rst last", 64'(m_last), 64'd0);
    chk_eq("rst busy", 64'(busy), 64'd0);
    chk_eq("rst done", 64'(done), 64'd0);
    rstn = 1'b1;

    drain("one_row", 10'd0, 11'd1, 1'b0, -1);
    drain("three_rows", 10'd5, 11'd3, 1'b0, 7);
    drain("wrap", 10'd1023, 11'd2, 1'b0, -1);
    drain("backpressure", 10'd20, 11'd2, 1'b1, -1);
    drain("zero_rows", 10'd3, 11'd0, 1'b0, -1);

    // Reset in the middle of SEND, while lane 4 is on the bus.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; num_rows = 11'd1; m_ready = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk_eq("mid lane4 vld", 64'(m_valid), 64'd1);
    chk_eq("mid lane4 dat", 64'(m_data), 64'd5);
    rstn = 1'b0;
    @(negedge clk);
    chk_eq("mid_rst rd_en", 64'(sram_rd_en), 64'd0);
    chk_eq("mid_rst addr", 64'(sram_address), 64'd0);
    chk_eq("mid_rst valid", 64'(m_valid), 64'd0);
    chk_eq("mid_rst data", 64'(m_data), 64'd0);
    chk_eq("mid_rst last", 64'(m_last), 64'd0);
    chk_eq("mid_rst busy", 64'(busy), 64'd0);
    chk_eq("mid_rst done", 64'(done), 64'd0);
    rstn = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || m_valid) saw_done++;
    end
    chk_eq("mid_rst quiet", 64'(saw_done), 64'd0);

    drain("post_rst", 10'd0, 11'd1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
